// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pkg
//  Purpose  : Shared types and constants for the immediate-generation stage:
//             immediate-type select, stage occupancy states, RV32I opcodes and
//             the opcode-to-immediate-type decoder used by autodecode builds.
//  Revision : 1.0  initial release
// ============================================================================
package imm_gen_pkg;

  // Immediate-type select; codes 0-3 line up with the legacy 2-bit encoding.
  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_J   = 3'd3,
    IMM_U   = 3'd4,
    IMM_Z   = 3'd5,
    IMM_SH  = 3'd6,
    IMM_RSV = 3'd7
  } imm_type_e;

  // Occupancy of the main/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // RV32I major opcodes that carry an immediate.
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

  // funct3 values of OP-IMM that use a shift amount instead of an I immediate.
  localparam logic [2:0] c_f3_sll = 3'b001;
  localparam logic [2:0] c_f3_srl = 3'b101;

  // Map opcode/funct3 to an immediate type; unknown opcodes are reserved.
  function automatic imm_type_e decode_imm_type(input logic [6:0] opcode,
                                                input logic [2:0] funct3);
    imm_type_e t;
    t = IMM_RSV;
    case (opcode)
      c_opc_op_imm: t = (funct3 == c_f3_sll || funct3 == c_f3_srl) ? IMM_SH : IMM_I;
      c_opc_load,
      c_opc_jalr:   t = IMM_I;
      c_opc_store:  t = IMM_S;
      c_opc_branch: t = IMM_B;
      c_opc_jal:    t = IMM_J;
      c_opc_lui,
      c_opc_auipc:  t = IMM_U;
      c_opc_system: t = IMM_Z;
      default:      t = IMM_RSV;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_stage_extend.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend_core
//  Purpose  : Combinational immediate extraction and sign/zero extension to
//             XLEN bits (32 or 64), with a flag for the reserved select.
//  Revision : 1.0  initial release
// ============================================================================
module imm_extend_core
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Everything is built at 64 bits and truncated, which keeps the
  // replication counts positive for both XLEN settings.
  logic [63:0] w_ext;
  logic [5:0]  w_shamt;

  // Opcode bits never contribute to the immediate.
  logic w_unused_opc;
  assign w_unused_opc = ^instr[6:0];

  // Format-specific field gathering; reserved select yields zero and flags it.
  always_comb begin
    w_ext   = '0;
    illegal = 1'b0;
    case (imm_type_e'(imm_type))
      IMM_I:   w_ext = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   w_ext = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   w_ext = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_J:   w_ext = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      IMM_U:   w_ext = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_Z:   w_ext = {59'b0, instr[19:15]};
      IMM_SH:  w_ext = {58'b0, w_shamt};
      default: begin
        w_ext   = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Shift amounts grow to 6 bits on 64-bit datapaths.
  generate
    if (XLEN == 64) begin : g_xlen64
      assign w_shamt = instr[25:20];
      assign imm     = w_ext;
    end else begin : g_xlen32
      logic w_unused_hi;
      assign w_unused_hi = ^w_ext[63:32];
      assign w_shamt     = {1'b0, instr[24:20]};
      assign imm         = w_ext[31:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_stage
//  Purpose  : Registered immediate-generation stage with valid/ready flow
//             control, a main+skid register pair for full throughput and a
//             synchronous flush. Immediates are extended before capture.
//  Options  : IMM_GEN_AUTODECODE_EN - derive the immediate type from
//             in_instr[6:0] instead of in_imm_type.
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [2:0]      w_type;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;

`ifdef IMM_GEN_AUTODECODE_EN
  logic w_unused_type;
  assign w_unused_type = ^in_imm_type;
  assign w_type        = decode_imm_type(in_instr[6:0], in_instr[14:12]);
`else
  assign w_type = in_imm_type;
`endif

  imm_extend_core #(.XLEN(XLEN)) u_extend (
    .instr    (in_instr),
    .imm_type (w_type),
    .imm      (w_imm),
    .illegal  (w_ill)
  );

  stage_state_e    r_state, w_state_nxt;
  logic            r_in_ready, r_out_valid;
  logic            w_accept, w_drain;
  logic            w_load_main, w_load_skid, w_main_from_skid;

  logic [XLEN-1:0]  r_main_imm, r_skid_imm;
  logic [TAG_W-1:0] r_main_tag, r_skid_tag;
  logic             r_main_ill, r_skid_ill;

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_out_valid && out_ready;

  // Occupancy transitions and register load selects; flush wins over all.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_drain) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_state_nxt      = ST_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State plus handshake flags derived from the next state, so in_ready is a
  // flop output with no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Payload registers; main drives the outputs, skid absorbs one extra entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_main_ill <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_imm <= w_imm;
        r_main_tag <= in_tag;
        r_main_ill <= w_ill;
      end else if (w_main_from_skid) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
        r_main_ill <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= in_tag;
        r_skid_ill <= w_ill;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_main_imm;
  assign out_tag     = r_main_tag;
  assign out_illegal = r_main_ill;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_stage
//  Purpose  : Directed self-checking bench for imm_gen_stage (XLEN 32 and 64
//             instances driven in parallel).
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_type;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [7:0]  out_tag;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] instr, input logic [7:0] tg);
    in_valid    = 1'b1;
    in_imm_type = t;
    in_instr    = instr;
    in_tag      = tg;
  endtask

  // Instruction whose I immediate equals the tag (addi x0,x0,tag).
  function automatic logic [31:0] tag_instr(input logic [7:0] tg);
    return {4'h0, tg, 20'h00013};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got[$];
    logic [7:0] next_tag;
    logic       fire_in, fire_out;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_imm_type = 3'd0; in_tag = '0; out_ready = 1'b1;
    step(); step();
    check("rst_out_valid",   out_valid,   1'b0);
    check("rst_in_ready",    in_ready,    1'b1);
    check("rst_out_imm",     out_imm,     32'h0);
    check("rst_out_tag",     out_tag,     8'h0);
    check("rst_out_illegal", out_illegal, 1'b0);
    rst_n = 1'b1;

    // Streaming with out_ready high: one-cycle latency, one per cycle.
    drive(3'd0, 32'hFFF00093, 8'h11); step();
    check("I_valid",   out_valid,   1'b1);
    check("I_imm",     out_imm,     32'hFFFFFFFF);
    check("I_imm64",   out_imm64,   64'hFFFFFFFFFFFFFFFF);
    check("I_illegal", out_illegal, 1'b0);
    check("I_tag",     out_tag,     8'h11);
`ifndef IMM_GEN_AUTODECODE_EN
    drive(3'd2, 32'hFE000EE3, 8'h12); step();
    check("B_imm", out_imm, 32'hFFFFFFFC);
    check("B_tag", out_tag, 8'h12);
    drive(3'd4, 32'h123450B7, 8'h13); step();
    check("U_imm",   out_imm,   32'h12345000);
    check("U_imm64", out_imm64, 64'h0000000012345000);
    drive(3'd4, 32'h800000B7, 8'h14); step();
    check("Uneg_imm",   out_imm,   32'h80000000);
    check("Uneg_imm64", out_imm64, 64'hFFFFFFFF80000000);
    drive(3'd1, 32'hFE112E23, 8'h15); step();
    check("S_imm", out_imm, 32'hFFFFFFFC);
    drive(3'd3, 32'h0080006F, 8'h16); step();
    check("J_imm", out_imm, 32'h00000008);
    drive(3'd5, 32'hFFFFD073, 8'h17); step();
    check("Z_imm",   out_imm,   32'h0000001F);
    check("Z_imm64", out_imm64, 64'h000000000000001F);
    drive(3'd6, 32'h03F09093, 8'h18); step();
    check("SH_imm",   out_imm,   32'h0000001F);
    check("SH_imm64", out_imm64, 64'h000000000000003F);
`else
    drive(3'd7, 32'h00509093, 8'h12); step();
    check("AD_slli_imm",     out_imm,     32'h00000005);
    check("AD_slli_illegal", out_illegal, 1'b0);
    drive(3'd7, 32'hFE000EE3, 8'h13); step();
    check("AD_B_imm", out_imm, 32'hFFFFFFFC);
    drive(3'd7, 32'h123450B7, 8'h14); step();
    check("AD_U_imm", out_imm, 32'h12345000);
    drive(3'd0, 32'h00000033, 8'h15); step();
    check("AD_R_illegal", out_illegal, 1'b1);
    check("AD_R_imm",     out_imm,     32'h0);
`endif
    drive(3'd7, 32'hFFFFFFFF, 8'h19); step();
    check("RSV_imm",     out_imm,     32'h0);
    check("RSV_imm64",   out_imm64,   64'h0);
    check("RSV_illegal", out_illegal, 1'b1);
    in_valid = 1'b0; step();
    check("drain_valid", out_valid, 1'b0);

    // Backpressure: tags 1..4 offered with out_ready low.
    out_ready = 1'b0;
    drive(3'd0, tag_instr(8'd1), 8'd1); step();
    check("bp1_in_ready", in_ready, 1'b1);
    check("bp1_tag",      out_tag,  8'd1);
    drive(3'd0, tag_instr(8'd2), 8'd2); step();
    check("bp2_in_ready",  in_ready,  1'b0);
    check("bp2_out_valid", out_valid, 1'b1);
    check("bp2_tag",       out_tag,   8'd1);
    drive(3'd0, tag_instr(8'd3), 8'd3); step();
    check("bp3_in_ready", in_ready, 1'b0);
    check("bp3_tag_hold", out_tag,  8'd1);
    check("bp3_imm_hold", out_imm,  32'd1);
    out_ready = 1'b1;
    next_tag  = 8'd3;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        got.push_back(out_tag);
        check("bp_imm_matches_tag", out_imm, {24'h0, out_tag});
      end
      step();
      if (fire_in) begin
        if (next_tag == 8'd4) in_valid = 1'b0;
        else begin
          next_tag = next_tag + 8'd1;
          drive(3'd0, tag_instr(next_tag), next_tag);
        end
      end
    end
    check("bp_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      check("bp_order", (k < got.size()) ? got[k] : 8'hEE, 8'(k + 1));
    in_valid = 1'b0; step();
    check("bp_no_dup", out_valid, 1'b0);

    // Flush while full with a simultaneous input.
    out_ready = 1'b0;
    drive(3'd0, tag_instr(8'h21), 8'h21); step();
    drive(3'd0, tag_instr(8'h22), 8'h22); step();
    check("fl_full", in_ready, 1'b0);
    drive(3'd0, tag_instr(8'h23), 8'h23);
    flush = 1'b1; step();
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready",  in_ready,  1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    check("fl_dropped", out_valid, 1'b0);

    // Asynchronous reset in the middle of a burst.
    out_ready = 1'b0;
    drive(3'd0, tag_instr(8'h31), 8'h31); step();
    drive(3'd0, tag_instr(8'h32), 8'h32); step();
    check("ar_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid",   out_valid,   1'b0);
    check("ar_in_ready",    in_ready,    1'b1);
    check("ar_out_imm",     out_imm,     32'h0);
    check("ar_out_tag",     out_tag,     8'h0);
    check("ar_out_illegal", out_illegal, 1'b0);
    check("ar_out_valid64", out_valid64, 1'b0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("ar_after_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
